// File: rtl/mxu_pkg.sv
// Shared constants, FSM state type and packing helper for the sequential MXU.
package mxu_pkg;

    localparam int MXU_N     = 3;
    localparam int MXU_W     = 16;
    localparam int MXU_ACC_W = 40;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } mxu_state_t;

    // LSB position of element (i,j) in a row-major packed N x N matrix
    function automatic int elem_lsb(input int i, input int j, input int n, input int w);
        return (i * n + j) * w;
    endfunction

endpackage

// File: rtl/mxu_seq_if.sv
// Job/result handshake bundle between a matrix-job producer and the MXU.
interface mxu_seq_if #(
    parameter int N = 3,
    parameter int W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             acc_en;
    logic             sat_en;
    logic [N*N*W-1:0] a_in;
    logic [N*N*W-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [N*N*W-1:0] c_out;

    modport master (
        output in_valid, acc_en, sat_en, a_in, b_in, out_ready,
        input  in_ready, out_valid, c_out
    );

    modport slave (
        input  in_valid, acc_en, sat_en, a_in, b_in, out_ready,
        output in_ready, out_valid, c_out
    );
endinterface

// File: rtl/mxu_mac_cell.sv
// One MAC accumulator of the MXU array, with its truncate/saturate output stage.
module mxu_mac_cell #(
    parameter int W     = 16,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             sat,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [ACC_W-1:0] acc,
    output logic [W-1:0]     res
);

    logic [2*W-1:0] prod;
    logic           over;

    assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(ACC_W-2*W){1'b0}}, prod};
        end
    end

    // Anything above bit W-1 means the value no longer fits the output element
    assign over = |acc[ACC_W-1:W];

    always_comb begin
        res = acc[W-1:0];
        if (sat && over) begin
            res = '1;
        end
    end

endmodule

// File: rtl/mxu_seq.sv
// Sequential N x N matrix multiply/accumulate: one outer-product term per cycle.
module mxu_seq
    import mxu_pkg::*;
#(
    parameter int N     = MXU_N,
    parameter int W     = MXU_W,
    parameter int ACC_W = MXU_ACC_W
) (
    input  logic      clk,
    input  logic      rst,
    mxu_seq_if.slave  bus
);

    localparam int KW = $clog2(N);

    mxu_state_t       state;
    logic [KW-1:0]    k_q;
    logic [N*N*W-1:0] a_q;
    logic [N*N*W-1:0] b_q;
    logic             sat_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             accept;
    logic             clr;
    logic             mac_en;
    logic [W-1:0]     a_col [N];
    logic [W-1:0]     b_row [N];

    assign accept = (state == IDLE) && bus.in_valid;
    assign clr    = accept && !bus.acc_en;
    assign mac_en = (state == COMPUTE);

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a_in;
                        b_q        <= bus.b_in;
                        sat_q      <= bus.sat_en;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (k_q == KW'(N-1)) begin
                        k_q         <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    // Accumulators stay untouched so a later acc_en job can build on them
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Column k of A feeds row i, row k of B feeds column j
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_col[i] = a_q[elem_lsb(i, int'(k_q), N, W) +: W];
            b_row[i] = b_q[elem_lsb(int'(k_q), i, N, W) +: W];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [ACC_W-1:0] acc;
            logic [W-1:0]     res;

            mxu_mac_cell #(
                .W     (W),
                .ACC_W (ACC_W)
            ) u_cell (
                .clk   (clk),
                .rst   (rst),
                .clear (clr),
                .en    (mac_en),
                .sat   (sat_q),
                .a     (a_col[i]),
                .b     (b_row[j]),
                .acc   (acc),
                .res   (res)
            );

            assign bus.c_out[elem_lsb(i, j, N, W) +: W] = res;
        end
    end

endmodule
